// File: rtl/move_select_pkg.sv
// Shared definitions for the move_select sequencer.
//   state_e      : sequencer FSM state encoding
//   FETCH_CNT_W  : width of the RAM latency counter (RAM_LATENCY 0..15)
package move_select_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EVAL_REQ,
    ST_EVAL_WAIT,
    ST_CAPTURE,
    ST_NEXT,
    ST_TERMINAL,
    ST_DONE,
    ST_CLEAR
  } state_e;

  localparam int RAM_LATENCY_MAX = 15;
  localparam int FETCH_CNT_W     = 4;

endpackage

// File: rtl/move_select_if.sv
// Bundle of the move_select handshake signals towards all_moves, evaluate
// and display_board, plus the result outputs.
//   slave  : seen from move_select (consumes list/eval status, drives
//            move_index, strobes and results)
//   master : seen from the surrounding system
interface move_select_if #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int EVAL_WIDTH         = 22
);
  // all_moves side
  logic                          moves_ready;
  logic [MAX_POSITIONS_LOG2-1:0] move_count;
  logic                          mate;
  logic                          stalemate;
  logic                          white_to_move;
  logic [MAX_POSITIONS_LOG2-1:0] move_index;
  logic                          clear_moves;
  // evaluate side
  logic signed [EVAL_WIDTH-1:0]  eval;
  logic                          eval_valid;
  logic                          eval_start;
  logic                          clear_eval;
  // display_board side
  logic                          display_done;
  logic                          display_move;
  // results
  logic [MAX_POSITIONS_LOG2-1:0] best_index;
  logic signed [EVAL_WIDTH-1:0]  best_eval;
  logic                          result_valid;
  logic                          result_mate;
  logic                          result_stalemate;
  logic                          result_timeout;
  logic                          busy;

  modport slave (
    input  moves_ready, move_count, mate, stalemate, white_to_move,
           eval, eval_valid, display_done,
    output move_index, clear_moves, eval_start, clear_eval, display_move,
           best_index, best_eval, result_valid, result_mate,
           result_stalemate, result_timeout, busy
  );

  modport master (
    output moves_ready, move_count, mate, stalemate, white_to_move,
           eval, eval_valid, display_done,
    input  move_index, clear_moves, eval_start, clear_eval, display_move,
           best_index, best_eval, result_valid, result_mate,
           result_stalemate, result_timeout, busy
  );

endinterface

// File: rtl/move_select_eval_best_tracker.sv
// Best-move register for move_select.
//   clear     : zero best_index/best_eval (start of a new list)
//   load      : best_index=0, best_eval=load_eval (mate/stalemate verdict)
//   update    : offer eval_in/index_in as a candidate
//   first     : candidate is move 0, always taken
//   stm_white : maximise when 1, minimise when 0 (signed compare)
// Strict compare means a tie keeps the earlier (lower) index.
module move_select_eval_best_tracker
  import move_select_pkg::*;
#(
  parameter int IDX_W  = 8,
  parameter int EVAL_W = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic signed [EVAL_W-1:0] load_eval,
  input  logic                     update,
  input  logic                     first,
  input  logic                     stm_white,
  input  logic [IDX_W-1:0]         index_in,
  input  logic signed [EVAL_W-1:0] eval_in,
  output logic [IDX_W-1:0]         best_index,
  output logic signed [EVAL_W-1:0] best_eval
);

  logic better;

  always_comb begin
    better = first || (stm_white ? (eval_in > best_eval) : (eval_in < best_eval));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_index <= '0;
      best_eval  <= '0;
    end else if (clear) begin
      best_index <= '0;
      best_eval  <= '0;
    end else if (load) begin
      best_index <= '0;
      best_eval  <= load_eval;
    end else if (update && better) begin
      best_index <= index_in;
      best_eval  <= eval_in;
    end
  end

endmodule

// File: rtl/move_select.sv
// Sequencer between all_moves and evaluate. Once moves_ready is seen it
// walks move_index over the list, requests an evaluation per move, keeps
// the best score for the side to move and reports it (or a mate/stalemate
// verdict), then pulses clear_moves so all_moves can restart.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : move_select_if.slave (list status, eval handshake,
//                display handshake, results, busy)
module move_select
  import move_select_pkg::*;
#(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int EVAL_WIDTH         = 22,
  parameter int RAM_LATENCY        = 1,
  parameter int DISPLAY_EN         = 0,
  parameter int EVAL_TIMEOUT       = 1023
) (
  input  logic         clk,
  input  logic         reset,
  move_select_if.slave bus
);

  localparam int N      = MAX_POSITIONS_LOG2;
  localparam int WAIT_W = $clog2(EVAL_TIMEOUT + 1);
  localparam logic signed [EVAL_WIDTH-1:0] MATE_POS = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [EVAL_WIDTH-1:0] MATE_NEG = -MATE_POS;

  state_e                   state, state_nxt;
  logic                     stm_white;
  logic                     mate_q;
  logic                     stale_q;
  logic [N-1:0]             cnt;
  logic [FETCH_CNT_W-1:0]   fetch_cnt;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     eval_seen;
  logic                     disp_seen;
  logic signed [EVAL_WIDTH-1:0] eval_q;

  logic                     start;
  logic                     in_wait;
  logic                     fetch_last;
  logic                     capture_ready;
  logic                     wait_expired;
  logic                     timeout_abort;
  logic                     more_moves;
  logic [N:0]               index_inc;
  logic signed [EVAL_WIDTH-1:0] term_eval;

  // Datapath decodes shared by the FSM and the registers.
  always_comb begin
    start   = (state == ST_IDLE) && bus.moves_ready;
    in_wait = (state == ST_EVAL_WAIT);
    // Leaves FETCH after max(1, RAM_LATENCY) cycles.
    fetch_last = ({1'b0, fetch_cnt} + (FETCH_CNT_W+1)'(1)) >= (FETCH_CNT_W+1)'(RAM_LATENCY);
    // eval and display_done may arrive in either order; each is latched.
    capture_ready = (eval_seen || bus.eval_valid) &&
                    ((DISPLAY_EN == 0) || disp_seen || bus.display_done);
    wait_expired  = (wait_cnt == WAIT_W'(EVAL_TIMEOUT - 1));
    timeout_abort = in_wait && !capture_ready && wait_expired;
    // One extra bit so a full list of 2^N-1 moves cannot wrap the compare.
    index_inc  = {1'b0, bus.move_index} + (N+1)'(1);
    more_moves = index_inc < {1'b0, cnt};
    term_eval  = mate_q ? (stm_white ? MATE_NEG : MATE_POS) : '0;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (bus.moves_ready)
                      state_nxt = (bus.move_count == '0) ? ST_TERMINAL : ST_FETCH;
      ST_FETCH:     if (fetch_last) state_nxt = ST_EVAL_REQ;
      ST_EVAL_REQ:  state_nxt = ST_EVAL_WAIT;
      ST_EVAL_WAIT: if (capture_ready)     state_nxt = ST_CAPTURE;
                    else if (wait_expired) state_nxt = ST_DONE;
      ST_CAPTURE:   state_nxt = ST_NEXT;
      ST_NEXT:      state_nxt = more_moves ? ST_FETCH : ST_DONE;
      ST_TERMINAL:  state_nxt = ST_DONE;
      ST_DONE:      state_nxt = ST_CLEAR;
      // Hold until all_moves drops its level so a stale moves_ready
      // cannot start a second scan of the same list.
      ST_CLEAR:     if (!bus.moves_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.eval_start   = (state == ST_EVAL_REQ);
    bus.display_move = (state == ST_EVAL_REQ) && (DISPLAY_EN != 0);
    bus.clear_eval   = (state == ST_CAPTURE);
    bus.result_valid = (state == ST_DONE);
    bus.clear_moves  = (state == ST_DONE);
    bus.busy         = (state != ST_IDLE);
  end

  // Latched list parameters, counters, handshake latches, sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stm_white            <= 1'b0;
      mate_q               <= 1'b0;
      stale_q              <= 1'b0;
      cnt                  <= '0;
      fetch_cnt            <= '0;
      wait_cnt             <= '0;
      eval_seen            <= 1'b0;
      disp_seen            <= 1'b0;
      eval_q               <= '0;
      bus.move_index       <= '0;
      bus.result_mate      <= 1'b0;
      bus.result_stalemate <= 1'b0;
      bus.result_timeout   <= 1'b0;
    end else begin
      fetch_cnt <= (state == ST_FETCH) ? fetch_cnt + FETCH_CNT_W'(1) : '0;
      wait_cnt  <= in_wait ? wait_cnt + WAIT_W'(1) : '0;
      eval_seen <= in_wait && (eval_seen || bus.eval_valid);
      disp_seen <= in_wait && (disp_seen || bus.display_done);
      if (in_wait && bus.eval_valid && !eval_seen) eval_q <= bus.eval;

      if (start) begin
        stm_white            <= bus.white_to_move;
        cnt                  <= bus.move_count;
        mate_q               <= bus.mate;
        stale_q              <= bus.stalemate;
        bus.move_index       <= '0;
        bus.result_mate      <= 1'b0;
        bus.result_stalemate <= 1'b0;
        bus.result_timeout   <= 1'b0;
      end

      if (state == ST_NEXT && more_moves) bus.move_index <= index_inc[N-1:0];

      // Mate takes precedence if both verdicts are (inconsistently) set.
      if (state == ST_TERMINAL) begin
        bus.result_mate      <= mate_q;
        bus.result_stalemate <= !mate_q && stale_q;
      end

      if (timeout_abort) bus.result_timeout <= 1'b1;
    end
  end

  move_select_eval_best_tracker #(
    .IDX_W  (N),
    .EVAL_W (EVAL_WIDTH)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .load       (state == ST_TERMINAL),
    .load_eval  (term_eval),
    .update     (state == ST_CAPTURE),
    .first      (bus.move_index == '0),
    .stm_white  (stm_white),
    .index_in   (bus.move_index),
    .eval_in    (eval_q),
    .best_index (bus.best_index),
    .best_eval  (bus.best_eval)
  );

endmodule
